// File: rtl/ram_responder.sv
// Memory-side responder for the unified RAM interface: a word array with bit-masked
// writes, an address window check, sticky error flags and a post-reset clear sequencer.
module ram_responder #(
  parameter logic [63:0] BASE_ADDR      = 64'h0000_0000_8000_0000,
  parameter int          DEPTH          = 4096,
  parameter int          READ_LAT       = 0,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RamReadEnable,
  input  logic [63:0] RamReadAddr,
  output logic [63:0] RamReadData,
  input  logic        RamWriteEnable,
  input  logic [63:0] RamWriteAddr,
  input  logic [63:0] RamWriteMask,
  input  logic [63:0] RamWriteData,
  output logic        ram_ready,
  output logic        rd_err,
  output logic        wr_err,
  output logic [15:0] err_cnt
);

  localparam int              AW       = $clog2(DEPTH);
  localparam logic [AW-1:0]   LAST_IDX = AW'(DEPTH - 1);

  typedef enum logic {ST_CLEAR, ST_READY} state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] clr_idx;
  logic          clr_we;
  logic [63:0]   mem [DEPTH];

  // Window check works on word addresses; BASE_ADDR is assumed 8-byte aligned.
  logic [60:0]   rd_woff, wr_woff;
  logic          rd_in, wr_in;
  logic [AW-1:0] rd_idx, wr_idx;
  logic          rd_ok, wr_ok, rd_bad, wr_bad;
  logic [63:0]   rd_word, merged;
  logic [16:0]   err_sum;
  logic          unused_addr_bits;

  assign unused_addr_bits = ^{RamReadAddr[1:0], RamWriteAddr[2:0]};

  assign rd_woff = RamReadAddr[63:3]  - BASE_ADDR[63:3];
  assign wr_woff = RamWriteAddr[63:3] - BASE_ADDR[63:3];
  assign rd_in   = (RamReadAddr[63:3]  >= BASE_ADDR[63:3]) && (rd_woff < 61'(DEPTH));
  assign wr_in   = (RamWriteAddr[63:3] >= BASE_ADDR[63:3]) && (wr_woff < 61'(DEPTH));
  assign rd_idx  = rd_woff[AW-1:0];
  assign wr_idx  = wr_woff[AW-1:0];

  assign rd_ok  = ram_ready && RamReadEnable  &&  rd_in;
  assign wr_ok  = ram_ready && RamWriteEnable &&  wr_in;
  assign rd_bad = ram_ready && RamReadEnable  && !rd_in;
  assign wr_bad = ram_ready && RamWriteEnable && !wr_in;

  assign rd_word = mem[rd_idx];
  assign merged  = (mem[wr_idx] & ~RamWriteMask) | (RamWriteData & RamWriteMask);

  function automatic logic [63:0] lane_sel(input logic [63:0] w, input logic hi);
    return hi ? {w[31:0], w[63:32]} : w;
  endfunction

  // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    clr_we    = 1'b0;
    ram_ready = 1'b0;
    unique case (state)
      ST_CLEAR: begin
        clr_we = 1'b1;
        if (clr_idx == LAST_IDX) state_nxt = ST_READY;
      end
      ST_READY: ram_ready = 1'b1;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLEAR_ON_RESET ? ST_CLEAR : ST_READY;
      clr_idx <= '0;
    end else begin
      state <= state_nxt;
      if (clr_we) clr_idx <= clr_idx + 1'b1;
    end
  end

  // NOTE: the array itself has no reset term; zeroing it is the clear sequencer's job, which keeps it mappable to RAM.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (clr_we)     mem[clr_idx] <= '0;
      else if (wr_ok) mem[wr_idx]  <= merged;
    end
  end

  assign err_sum = {1'b0, err_cnt} + 17'(rd_bad) + 17'(wr_bad);

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_err  <= 1'b0;
      wr_err  <= 1'b0;
      err_cnt <= '0;
    end else begin
      if (rd_bad) rd_err <= 1'b1;
      if (wr_bad) wr_err <= 1'b1;
      err_cnt <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
    end
  end

  generate
    if (READ_LAT == 0) begin : g_lat0
      // Same-cycle writes land on the edge, so this path returns the old word.
      assign RamReadData = rd_ok ? lane_sel(rd_word, RamReadAddr[2]) : '0;
    end else begin : g_lat1
      logic [63:0] rd_q;
      logic [63:0] fwd_word;
      assign fwd_word = (wr_ok && (wr_idx == rd_idx)) ? merged : rd_word;
      always_ff @(posedge clk) begin
        if (rst)                rd_q <= '0;
        else if (RamReadEnable) rd_q <= rd_ok ? lane_sel(fwd_word, RamReadAddr[2]) : '0;
      end
      assign RamReadData = rd_q;
    end
  endgenerate

endmodule

// File: tb/tb_ram_responder.sv
// Bench for ram_responder: both read latencies side by side, a spec-level model checked
// every cycle, plus directed literal expectations.
module tb_ram_responder;
  localparam int          DEPTH = 16;
  localparam logic [63:0] BASE  = 64'h0000_0000_8000_0000;
  localparam logic [63:0] ONES  = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        clk = 1'b0, rst = 1'b1;
  logic        re = 1'b0, we = 1'b0;
  logic [63:0] ra = '0, wa = '0, wm = '0, wd = '0;
  logic [63:0] rd0, rd1;
  logic        rdy0, rdy1, rerr0, rerr1, werr0, werr1;
  logic [15:0] cnt0, cnt1;

  always #5 clk = ~clk;

  ram_responder #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .READ_LAT(0), .CLEAR_ON_RESET(1'b1)) u_lat0 (
    .clk(clk), .rst(rst),
    .RamReadEnable(re), .RamReadAddr(ra), .RamReadData(rd0),
    .RamWriteEnable(we), .RamWriteAddr(wa), .RamWriteMask(wm), .RamWriteData(wd),
    .ram_ready(rdy0), .rd_err(rerr0), .wr_err(werr0), .err_cnt(cnt0));

  ram_responder #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .READ_LAT(1), .CLEAR_ON_RESET(1'b1)) u_lat1 (
    .clk(clk), .rst(rst),
    .RamReadEnable(re), .RamReadAddr(ra), .RamReadData(rd1),
    .RamWriteEnable(we), .RamWriteAddr(wa), .RamWriteMask(wm), .RamWriteData(wd),
    .ram_ready(rdy1), .rd_err(rerr1), .wr_err(werr1), .err_cnt(cnt1));

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: plain address arithmetic over a word array.
  logic [63:0] m_mem [DEPTH];
  bit          m_ready, m_rerr, m_werr;
  int          m_clr, m_cnt;
  logic [63:0] m_rd1;

  function automatic bit in_win(input logic [63:0] a);
    return (a >= BASE) && (a < BASE + 64'(8 * DEPTH));
  endfunction

  function automatic int word_of(input logic [63:0] a);
    return int'((a - BASE) / 8);
  endfunction

  function automatic logic [63:0] pick(input logic [63:0] w, input logic [63:0] a);
    logic [63:0] half;
    half = (a / 4) % 2;
    return (half != 0) ? {w[31:0], w[63:32]} : w;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_ready = 1'b0; m_clr = 0; m_rerr = 1'b0; m_werr = 1'b0; m_cnt = 0; m_rd1 = '0;
    end else if (!m_ready) begin
      if (re) m_rd1 = '0;
      m_mem[m_clr] = '0;
      if (m_clr == DEPTH - 1) m_ready = 1'b1;
      m_clr++;
    end else begin
      // Apply the write first; the registered read then sees post-write contents.
      if (we && in_win(wa))
        m_mem[word_of(wa)] = (m_mem[word_of(wa)] & ~wm) | (wd & wm);
      if (re) m_rd1 = in_win(ra) ? pick(m_mem[word_of(ra)], ra) : '0;
      if (re && !in_win(ra)) begin m_rerr = 1'b1; m_cnt++; end
      if (we && !in_win(wa)) begin m_werr = 1'b1; m_cnt++; end
      if (m_cnt > 65535) m_cnt = 65535;
    end
  end

  always @(negedge clk) begin
    logic [63:0] e0;
    if (chk_en) begin
      e0 = '0;
      if (m_ready && re && in_win(ra)) e0 = pick(m_mem[word_of(ra)], ra);
      check("rdata_lat0", rd0, e0);
      check("rdata_lat1", rd1, m_rd1);
      check("ready_lat0", 64'(rdy0), 64'(m_ready));
      check("ready_lat1", 64'(rdy1), 64'(m_ready));
      check("rd_err_lat0", 64'(rerr0), 64'(m_rerr));
      check("rd_err_lat1", 64'(rerr1), 64'(m_rerr));
      check("wr_err_lat0", 64'(werr0), 64'(m_werr));
      check("wr_err_lat1", 64'(werr1), 64'(m_werr));
      check("err_cnt_lat0", 64'(cnt0), 64'(m_cnt));
      check("err_cnt_lat1", 64'(cnt1), 64'(m_cnt));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input bit e, input logic [63:0] a);
    re = e; ra = a;
  endtask

  task automatic set_wr(input bit e, input logic [63:0] a, input logic [63:0] m, input logic [63:0] d);
    we = e; wa = a; wm = m; wd = d;
  endtask

  // Counts negedges with ram_ready low after rst has fallen; bounded at 40.
  task automatic count_clear(output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rdy0) break;
      n++;
      @(posedge clk);
      #1;
    end
  endtask

  int n_clr;

  initial begin
    repeat (2) step();
    @(negedge clk);
    check("reset_ready", 64'(rdy0), 64'd0);
    check("reset_err_cnt", 64'(cnt0), 64'd0);
    check("reset_rdata_lat1", rd1, 64'd0);
    step();
    rst = 1'b0;
    chk_en = 1'b1;

    count_clear(n_clr);
    check("clear_cycles", 64'(n_clr), 64'd16);
    step();

    set_rd(1'b1, BASE);
    @(negedge clk); check("cleared_word0", rd0, 64'd0);
    step();

    set_rd(1'b0, '0);
    set_wr(1'b1, BASE + 64'h8, ONES, 64'h1122334455667788);
    step();
    set_wr(1'b0, '0, '0, '0);
    set_rd(1'b1, BASE + 64'h8);
    @(negedge clk); check("read_low_lane", rd0, 64'h1122334455667788);
    step();
    set_rd(1'b1, BASE + 64'hC);
    @(negedge clk);
    check("read_high_lane", rd0, 64'h5566778811223344);
    check("lat1_low_lane", rd1, 64'h1122334455667788);
    step();
    set_rd(1'b1, BASE + 64'hD);
    @(negedge clk);
    check("low_bits_ignored", rd0, 64'h5566778811223344);
    check("lat1_high_lane", rd1, 64'h5566778811223344);
    step();

    set_rd(1'b0, '0);
    set_wr(1'b1, BASE + 64'h20, ONES, 64'h11111111_22222222);
    step();
    set_wr(1'b1, BASE + 64'h23, 64'h00000000_FFFFFFFF, 64'hAAAAAAAA_BBBBBBBB);
    set_rd(1'b1, BASE + 64'h20);
    @(negedge clk); check("same_cycle_old_lat0", rd0, 64'h11111111_22222222);
    step();
    set_wr(1'b0, '0, '0, '0);
    @(negedge clk);
    check("masked_write", rd0, 64'h11111111_BBBBBBBB);
    check("masked_forward_lat1", rd1, 64'h11111111_BBBBBBBB);
    step();
    set_wr(1'b1, BASE + 64'h20, 64'd0, ONES);
    step();
    set_wr(1'b0, '0, '0, '0);
    @(negedge clk); check("zero_mask_no_change", rd0, 64'h11111111_BBBBBBBB);
    step();

    set_wr(1'b1, BASE + 64'h10, ONES, 64'hDEAD);
    set_rd(1'b1, BASE + 64'h10);
    @(negedge clk); check("forward_old_lat0", rd0, 64'd0);
    step();
    set_wr(1'b0, '0, '0, '0);
    set_rd(1'b0, BASE + 64'h8);
    @(negedge clk); check("forward_lat1", rd1, 64'hDEAD);
    step();
    @(negedge clk); check("hold_lat1", rd1, 64'hDEAD);
    step();

    set_wr(1'b1, BASE + 64'h78, ONES, 64'hCAFEF00D_12345678);
    set_rd(1'b1, BASE + 64'h8);
    @(negedge clk); check("independent_lat0", rd0, 64'h1122334455667788);
    step();
    set_wr(1'b0, '0, '0, '0);
    set_rd(1'b1, BASE + 64'h7C);
    @(negedge clk);
    check("last_word_high", rd0, 64'h12345678_CAFEF00D);
    check("independent_lat1", rd1, 64'h1122334455667788);
    step();

    set_rd(1'b1, 64'h7FFF_FFF8);
    set_wr(1'b1, BASE + 64'(8 * DEPTH), ONES, ONES);
    @(negedge clk);
    check("oow_read_lat0", rd0, 64'd0);
    check("rd_err_before", 64'(rerr0), 64'd0);
    step();
    set_rd(1'b0, '0);
    set_wr(1'b0, '0, '0, '0);
    @(negedge clk);
    check("rd_err_set", 64'(rerr0), 64'd1);
    check("wr_err_set", 64'(werr0), 64'd1);
    check("err_cnt_two", 64'(cnt0), 64'd2);
    check("oow_read_lat1", rd1, 64'd0);
    step();
    set_rd(1'b1, BASE);
    @(negedge clk); check("oow_write_dropped", rd0, 64'd0);
    step();

    set_rd(1'b1, 64'h7FFF_FFF8);
    set_wr(1'b1, BASE + 64'(8 * DEPTH), ONES, ONES);
    repeat (70000) step();
    set_rd(1'b0, '0);
    set_wr(1'b0, '0, '0, '0);
    @(negedge clk);
    check("err_cnt_saturated", 64'(cnt0), 64'hFFFF);
    check("err_cnt_saturated_lat1", 64'(cnt1), 64'hFFFF);
    step();

    rst = 1'b1;
    step();
    rst = 1'b0;
    set_wr(1'b1, BASE, ONES, ONES);
    repeat (5) step();
    set_wr(1'b0, '0, '0, '0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    count_clear(n_clr);
    check("restart_clear_cycles", 64'(n_clr), 64'd16);
    check("errors_cleared", 64'(rerr0), 64'd0);
    step();
    set_rd(1'b1, BASE);
    @(negedge clk); check("clear_write_dropped", rd0, 64'd0);
    step();
    set_rd(1'b1, BASE + 64'h20);
    @(negedge clk); check("word_recleared", rd0, 64'd0);
    step();
    set_rd(1'b0, '0);
    step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
